// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (800x600@72Hz from 50 MHz).
// Display blocks size tile coordinates with ADDR_W and these values.
package vga_timing_pkg;

    localparam int ADDR_W = 11;

    localparam int H_SYNC_D   = 120;
    localparam int H_BACK_D   = 64;
    localparam int H_ACTIVE_D = 800;
    localparam int H_FRONT_D  = 56;

    localparam int V_SYNC_D   = 6;
    localparam int V_BACK_D   = 23;
    localparam int V_ACTIVE_D = 600;
    localparam int V_FRONT_D  = 37;

    localparam int H_TOTAL =
        H_SYNC_D + H_BACK_D + H_ACTIVE_D + H_FRONT_D;
    localparam int V_TOTAL =
        V_SYNC_D + V_BACK_D + V_ACTIVE_D + V_FRONT_D;

    localparam int H_START = H_SYNC_D + H_BACK_D;
    localparam int V_START = V_SYNC_D + V_BACK_D;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth register delay for sync/qualifier bits.
// Reset flushes every stage to the inactive vector.
module sync_delay_line #(
    parameter int          W     = 3,
    parameter int          DEPTH = 2,
    parameter logic [W-1:0] INACT = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_pass;
            assign unused_pass = clk ^ rst_n;
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++)
                        stage[i] <= INACT;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++)
                        stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: counters, pixel addresses, sync pulses.
// Delayed sync/ready outputs align with pipelined display blocks.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_SYNC   = H_SYNC_D,
    parameter int   H_BACK   = H_BACK_D,
    parameter int   H_ACTIVE = H_ACTIVE_D,
    parameter int   H_FRONT  = H_FRONT_D,
    parameter int   V_SYNC   = V_SYNC_D,
    parameter int   V_BACK   = V_BACK_D,
    parameter int   V_ACTIVE = V_ACTIVE_D,
    parameter int   V_FRONT  = V_FRONT_D,
    parameter logic SYNC_POL = 1'b1,
    parameter int   PIPE_DLY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] col_addr_sig,
    output logic [ADDR_W-1:0] row_addr_sig,
    output logic              ready,
    output logic              line_start,
    output logic              frame_start,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              ready_dly
);

    localparam logic [ADDR_W-1:0] H_SY =
        ADDR_W'(H_SYNC);
    localparam logic [ADDR_W-1:0] H_ST =
        ADDR_W'(H_SYNC + H_BACK);
    localparam logic [ADDR_W-1:0] H_EN =
        ADDR_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [ADDR_W-1:0] H_LAST =
        ADDR_W'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);

    localparam logic [ADDR_W-1:0] V_SY =
        ADDR_W'(V_SYNC);
    localparam logic [ADDR_W-1:0] V_ST =
        ADDR_W'(V_SYNC + V_BACK);
    localparam logic [ADDR_W-1:0] V_EN =
        ADDR_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [ADDR_W-1:0] V_LAST =
        ADDR_W'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] h_cnt;
    logic [ADDR_W-1:0] v_cnt;
    logic              h_act;
    logic              v_act;
    logic              act;
    logic              hs_int;
    logic              vs_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
        end else begin
            h_cnt <= h_cnt + ONE;
        end
    end

    assign h_act = (h_cnt >= H_ST) && (h_cnt < H_EN);
    assign v_act = (v_cnt >= V_ST) && (v_cnt < V_EN);
    assign act   = h_act && v_act;

    // Both addresses leave zero together, only inside the window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_addr_sig <= '0;
            row_addr_sig <= '0;
            ready        <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            hs_int       <= ~SYNC_POL;
            vs_int       <= ~SYNC_POL;
        end else begin
            col_addr_sig <= act ? h_cnt - H_ST + ONE : '0;
            row_addr_sig <= act ? v_cnt - V_ST + ONE : '0;
            ready        <= act;
            line_start   <= (h_cnt == '0);
            frame_start  <= (h_cnt == '0) && (v_cnt == '0);
            hs_int       <= (h_cnt < H_SY) ? SYNC_POL : ~SYNC_POL;
            vs_int       <= (v_cnt < V_SY) ? SYNC_POL : ~SYNC_POL;
        end
    end

    sync_delay_line #(
        .W     (3),
        .DEPTH (PIPE_DLY),
        .INACT ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({hs_int, vs_int, ready}),
        .dout  ({hsync_o, vsync_o, ready_dly})
    );

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: cycle-index reference model scoreboard
// plus directed period/count checks on three parameterisations.
module tb_vga_sync_gen;

    typedef struct {
        int   hs, hb, ha, hf;
        int   vs, vb, va, vf;
        logic pol;
        int   dly;
    } tim_t;

    typedef struct packed {
        logic [10:0] col;
        logic [10:0] row;
        logic        rdy, ls, fs, hsy, vsy, rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] c0, r0, c1, r1, c2, r2;
    logic rd0, ls0, fs0, hs0, vs0, dl0;
    logic rd1, ls1, fs1, hs1, vs1, dl1;
    logic rd2, ls2, fs2, hs2, vs2, dl2;

    vga_sync_gen u0 (
        .clk(clk), .rst_n(rst_n),
        .col_addr_sig(c0), .row_addr_sig(r0),
        .ready(rd0), .line_start(ls0), .frame_start(fs0),
        .hsync_o(hs0), .vsync_o(vs0), .ready_dly(dl0)
    );

    vga_sync_gen #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(3),
        .SYNC_POL(1'b0), .PIPE_DLY(4)
    ) u1 (
        .clk(clk), .rst_n(rst_n),
        .col_addr_sig(c1), .row_addr_sig(r1),
        .ready(rd1), .line_start(ls1), .frame_start(fs1),
        .hsync_o(hs1), .vsync_o(vs1), .ready_dly(dl1)
    );

    vga_sync_gen #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(10), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(3),
        .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) u2 (
        .clk(clk), .rst_n(rst_n),
        .col_addr_sig(c2), .row_addr_sig(r2),
        .ready(rd2), .line_start(ls2), .frame_start(fs2),
        .hsync_o(hs2), .vsync_o(vs2), .ready_dly(dl2)
    );

    tim_t t0 = '{120, 64, 800, 56, 6, 23, 600, 37, 1'b1, 2};
    tim_t t1 = '{4, 3, 10, 2, 2, 2, 5, 3, 1'b0, 4};
    tim_t t2 = '{4, 3, 10, 2, 2, 2, 5, 3, 1'b1, 0};

    int errors = 0;
    int checks = 0;
    int k = 0;
    int phase = 0;
    exp_t q0[$], q1[$], q2[$];

    int ls_last0 = -1;
    logic rd0_prev = 1'b0;
    int first_rdy0 = -1;
    int first_hs0 = -1;
    int post_fs0 = -1;
    int fs_last1 = -1;
    int rdy_cnt1 = 0;
    int tile1 = 0;
    logic hist1 [8];

    function automatic logic in_win(tim_t t, int h, int v);
        return (h >= t.hs + t.hb) && (h < t.hs + t.hb + t.ha)
            && (v >= t.vs + t.vb) && (v < t.vs + t.vb + t.va);
    endfunction

    // State after the k-th clock edge with rst_n high (k=0: in reset).
    function automatic exp_t model(tim_t t, int kk);
        exp_t e;
        int ht, vt, p, h, v, q, hq, vq;
        ht = t.hs + t.hb + t.ha + t.hf;
        vt = t.vs + t.vb + t.va + t.vf;
        e = '0;
        e.hsy = ~t.pol;
        e.vsy = ~t.pol;
        if (kk == 0) return e;
        p = kk - 1;
        h = p % ht;
        v = (p / ht) % vt;
        if (in_win(t, h, v)) begin
            e.col = 11'(h - (t.hs + t.hb) + 1);
            e.row = 11'(v - (t.vs + t.vb) + 1);
            e.rdy = 1'b1;
        end
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        q = p - t.dly;
        if (q >= 0) begin
            hq = q % ht;
            vq = (q / ht) % vt;
            e.hsy = (hq < t.hs) ? t.pol : ~t.pol;
            e.vsy = (vq < t.vs) ? t.pol : ~t.pol;
            e.rd  = in_win(t, hq, vq);
        end
        return e;
    endfunction

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t g, input exp_t e);
        check({tag, ".col"}, 32'(g.col), 32'(e.col));
        check({tag, ".row"}, 32'(g.row), 32'(e.row));
        check({tag, ".flags"},
              32'({g.rdy, g.ls, g.fs, g.hsy, g.vsy, g.rd}),
              32'({e.rdy, e.ls, e.fs, e.hsy, e.vsy, e.rd}));
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (!rst_n) k = 0;
        else k++;
        q0.push_back(model(t0, k));
        q1.push_back(model(t1, k));
        q2.push_back(model(t2, k));
        @(negedge clk);
        e = q0.pop_front();
        cmp("u0", {c0, r0, rd0, ls0, fs0, hs0, vs0, dl0}, e);
        e = q1.pop_front();
        cmp("u1", {c1, r1, rd1, ls1, fs1, hs1, vs1, dl1}, e);
        e = q2.pop_front();
        cmp("u2", {c2, r2, rd2, ls2, fs2, hs2, vs2, dl2}, e);

        if (k == 0) begin
            ls_last0 = -1;
            fs_last1 = -1;
            rdy_cnt1 = 0;
            tile1 = 0;
        end
        if (phase == 1 && hs0 && first_hs0 < 0) first_hs0 = k;
        if (phase == 2 && fs0 && post_fs0 < 0) post_fs0 = k;
        if (ls0) begin
            if (ls_last0 >= 0)
                check("u0.line_period", k - ls_last0, 1040);
            ls_last0 = k;
        end
        if (rd0 && !rd0_prev) begin
            check("u0.ready_after_ls", k - ls_last0, 184);
            if (first_rdy0 < 0) first_rdy0 = k;
        end
        rd0_prev = rd0;
        if (fs1) begin
            if (fs_last1 >= 0) begin
                check("u1.frame_period", k - fs_last1, 228);
                check("u1.ready_per_frame", rdy_cnt1, 50);
                check("u1.tile_col7", tile1, 5);
            end
            fs_last1 = k;
            rdy_cnt1 = 0;
            tile1 = 0;
        end
        if (rd1) rdy_cnt1++;
        if (c1 == 11'd7) tile1++;
        hist1[k % 8] = rd1;
        if (k >= 4) check("u1.rdy_shift4", 32'(dl1), 32'(hist1[(k - 4) % 8]));
        check("u2.rdy_shift0", 32'(dl2), 32'(rd2));
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        phase = 1;
        repeat (31000) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        phase = 2;
        repeat (600) step();

        check("u0.first_hsync", first_hs0, 3);
        check("u0.first_ready", first_rdy0, 29 * 1040 + 184 + 1);
        check("u0.fs_after_rst", post_fs0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
